// File: rtl/rs485_slave_responder.sv
// rs485_slave_responder
//   Half-duplex RS485 slave front end. Receives UART-framed bytes on rx and
//   compares each good byte against SLAVE_ADDR. On a match it latches the
//   payload, enables the line driver, idles high for a turnaround period,
//   then sends N_BYTES framed bytes back-to-back (byte 0 first, LSB first).
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   rx         serial receive line (asynchronous, idle high)
//   payload    response bytes; byte k = payload[8k+7:8k]
//   tx_en      transceiver driver enable
//   tx         serial transmit line (idle high)
//   busy       high from addr_match through tx_done
//   addr_match one-cycle pulse on a good frame equal to SLAVE_ADDR
//   tx_done    one-cycle pulse when the last stop bit completes
//   frame_err  one-cycle pulse on bad stop bit or parity mismatch
module rs485_slave_responder #(
  parameter logic [7:0] SLAVE_ADDR      = 8'h01,
  parameter int         N_BYTES         = 2,
  parameter int         CLKS_PER_BIT    = 50,
  parameter int         PARITY_EN       = 0,
  parameter int         TURNAROUND_BITS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  input  logic [8*N_BYTES-1:0]   payload,
  output logic                   tx_en,
  output logic                   tx,
  output logic                   busy,
  output logic                   addr_match,
  output logic                   tx_done,
  output logic                   frame_err
);

  localparam int TURN_CYC = TURNAROUND_BITS * CLKS_PER_BIT;
  localparam int CMAX     = (TURN_CYC > CLKS_PER_BIT) ? TURN_CYC : CLKS_PER_BIT;
  localparam int CW       = $clog2(CMAX + 1);
  localparam int BW       = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  localparam logic [CW-1:0] HALF_END  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TURN_END  = CW'(TURN_CYC - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(N_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP,
    TURN, TX_START, TX_DATA, TX_PAR, TX_STOP
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           bit_idx, bit_n;
  logic [BW-1:0]        byte_idx, byte_n;
  logic [7:0]           rx_sh, rx_sh_n;
  logic                 rx_par, rx_par_n;
  logic [8*N_BYTES-1:0] tx_buf, tx_buf_n;
  logic                 tx_n, tx_en_n, busy_n, am_n, done_n, ferr_n;
  logic                 rx_s1, rx_s2, rx_prev;
  logic                 tick;

  // Two-flop synchroniser plus one extra stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      rx_sh      <= '0;
      rx_par     <= 1'b0;
      tx_buf     <= '0;
      tx         <= 1'b1;
      tx_en      <= 1'b0;
      busy       <= 1'b0;
      addr_match <= 1'b0;
      tx_done    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      byte_idx   <= byte_n;
      rx_sh      <= rx_sh_n;
      rx_par     <= rx_par_n;
      tx_buf     <= tx_buf_n;
      tx         <= tx_n;
      tx_en      <= tx_en_n;
      busy       <= busy_n;
      addr_match <= am_n;
      tx_done    <= done_n;
      frame_err  <= ferr_n;
    end
  end

  assign tick = (cnt == BIT_END);

  // Outputs are registered: each transition sets the tx level for the bit
  // that starts on the same edge, so every bit lasts exactly CLKS_PER_BIT.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    bit_n    = bit_idx;
    byte_n   = byte_idx;
    rx_sh_n  = rx_sh;
    rx_par_n = rx_par;
    tx_buf_n = tx_buf;
    tx_n     = tx;
    tx_en_n  = tx_en;
    busy_n   = busy;
    am_n     = 1'b0;
    done_n   = 1'b0;
    ferr_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_s2) state_n = RX_START;
      end
      RX_START: if (cnt == HALF_END) begin
        cnt_n   = '0;
        bit_n   = '0;
        state_n = rx_s2 ? IDLE : RX_DATA;  // high at mid-start = glitch
      end
      RX_DATA: if (tick) begin
        cnt_n   = '0;
        rx_sh_n = {rx_s2, rx_sh[7:1]};
        bit_n   = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_n = (PARITY_EN != 0) ? RX_PAR : RX_STOP;
      end
      RX_PAR: if (tick) begin
        cnt_n    = '0;
        rx_par_n = rx_s2;
        state_n  = RX_STOP;
      end
      RX_STOP: if (tick) begin
        cnt_n   = '0;
        state_n = IDLE;
        if (!rx_s2 || (PARITY_EN != 0 && (^rx_sh) != rx_par)) begin
          ferr_n = 1'b1;
        end else if (rx_sh == SLAVE_ADDR) begin
          am_n     = 1'b1;
          tx_buf_n = payload;
          busy_n   = 1'b1;
          tx_en_n  = 1'b1;
          byte_n   = '0;
          if (TURN_CYC == 0) begin
            state_n = TX_START;
            tx_n    = 1'b0;
          end else begin
            state_n = TURN;
          end
        end
      end
      TURN: if (cnt == TURN_END) begin
        cnt_n   = '0;
        state_n = TX_START;
        tx_n    = 1'b0;
      end
      TX_START: if (tick) begin
        cnt_n   = '0;
        bit_n   = '0;
        tx_n    = tx_buf[0];
        state_n = TX_DATA;
      end
      TX_DATA: if (tick) begin
        cnt_n = '0;
        if (bit_idx == 3'd7) begin
          if (PARITY_EN != 0) begin
            state_n = TX_PAR;
            tx_n    = ^tx_buf[7:0];
          end else begin
            state_n = TX_STOP;
            tx_n    = 1'b1;
          end
        end else begin
          bit_n = bit_idx + 3'd1;
          tx_n  = tx_buf[bit_idx + 3'd1];
        end
      end
      TX_PAR: if (tick) begin
        cnt_n   = '0;
        state_n = TX_STOP;
        tx_n    = 1'b1;
      end
      TX_STOP: if (tick) begin
        cnt_n = '0;
        if (byte_idx == LAST_BYTE) begin
          state_n = IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          tx_en_n = 1'b0;
          tx_n    = 1'b1;
          byte_n  = '0;
        end else begin
          // Start bit follows the stop bit with no idle gap.
          byte_n   = byte_idx + 1'b1;
          tx_buf_n = tx_buf >> 8;
          state_n  = TX_START;
          tx_n     = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rs485_slave_responder.sv
// Bench for rs485_slave_responder: two instances (no parity / even parity),
// CLKS_PER_BIT=8, two payload bytes, one turnaround bit. Stimulus pushes the
// expected event (response or frame error) to a per-instance queue; a monitor
// per instance pops it when the DUT raises addr_match/frame_err and checks the
// tx waveform cycle by cycle against a model built from the expected bytes.
module tb_rs485_slave_responder;
  localparam int CPB  = 8;
  localparam int NB   = 2;
  localparam int TURN = CPB;
  localparam int RESP = 1;
  localparam int FERR = 2;

  typedef struct {
    int          kind;
    logic [15:0] data;
    bit          abort;
  } exp_t;

  logic        clk, reset;
  logic [1:0]  rx;
  logic [15:0] payload0, payload1;
  logic [1:0]  tx, tx_en, busy, am, done, ferr;

  int   n_chk, n_fail;
  int   idle_bad [2];
  exp_t q0[$], q1[$];

  rs485_slave_responder #(.SLAVE_ADDR(8'h01), .N_BYTES(NB), .CLKS_PER_BIT(CPB),
    .PARITY_EN(0), .TURNAROUND_BITS(1)) u_dut0 (
    .clk(clk), .reset(reset), .rx(rx[0]), .payload(payload0), .tx_en(tx_en[0]),
    .tx(tx[0]), .busy(busy[0]), .addr_match(am[0]), .tx_done(done[0]), .frame_err(ferr[0]));

  rs485_slave_responder #(.SLAVE_ADDR(8'h01), .N_BYTES(NB), .CLKS_PER_BIT(CPB),
    .PARITY_EN(1), .TURNAROUND_BITS(1)) u_dut1 (
    .clk(clk), .reset(reset), .rx(rx[1]), .payload(payload1), .tx_en(tx_en[1]),
    .tx(tx[1]), .busy(busy[1]), .addr_match(am[1]), .tx_done(done[1]), .frame_err(ferr[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int d, input int kind, input logic [15:0] data, input bit abort);
    exp_t e;
    e.kind = kind; e.data = data; e.abort = abort;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic pop_exp(input int d, output exp_t e, output bit ok);
    e.kind = 0; e.data = '0; e.abort = 1'b0; ok = 1'b0;
    if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
    if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame: start, 8 data LSB first, [even parity], stop.
  task automatic send_byte(input int d, input logic [7:0] b, input bit par_good, input bit stop);
    logic [10:0] fr;
    int nb;
    nb = (d == 1) ? 11 : 10;
    if (d == 1) fr = {stop, (^b) ^ ~par_good, b, 1'b0};
    else        fr = {1'b1, stop, b, 1'b0};
    for (int i = 0; i < nb; i++) begin
      rx[d] = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx[d] = 1'b1;
  endtask

  task automatic mon(input int d);
    exp_t e;
    bit ok, aborted;
    int fb, total, wave_bad, en_bad, rel, k, p;
    logic [7:0] xb;
    logic exp_tx;
    logic [15:0] dec;
    fb = 10 + d;
    total = TURN + NB * fb * CPB;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (ferr[d]) begin
        pop_exp(d, e, ok);
        chk($sformatf("ferr_expected_d%0d", d), {ok, e.kind == FERR}, 2'b11);
        @(negedge clk);
        chk($sformatf("ferr_pulse_d%0d", d), ferr[d], 1'b0);
      end else if (am[d]) begin
        pop_exp(d, e, ok);
        chk($sformatf("am_expected_d%0d", d), {ok, e.kind == RESP}, 2'b11);
        wave_bad = 0; en_bad = 0; aborted = 1'b0; dec = '0;
        for (int i = 0; i < total; i++) begin
          if (i > 0) @(negedge clk);
          if (i < TURN) exp_tx = 1'b1;
          else begin
            rel = i - TURN;
            k   = rel / (CPB * fb);
            p   = (rel / CPB) % fb;
            xb  = e.data[k*8 +: 8];
            if (p == 0)                  exp_tx = 1'b0;
            else if (p <= 8)             exp_tx = xb[p-1];
            else if (p == 9 && fb == 11) exp_tx = ^xb;
            else                         exp_tx = 1'b1;
            if (rel % CPB == CPB / 2 && p >= 1 && p <= 8) dec[k*8 + p - 1] = tx[d];
          end
          if (tx[d] !== exp_tx) wave_bad++;
          if (tx_en[d] !== 1'b1 || busy[d] !== 1'b1 || done[d] !== 1'b0 ||
              (i > 0 && am[d] !== 1'b0)) en_bad++;
          if (reset) begin aborted = 1'b1; break; end
        end
        chk($sformatf("tx_wave_bad_d%0d", d), wave_bad, 0);
        chk($sformatf("busy_en_bad_d%0d", d), en_bad, 0);
        if (aborted) begin
          @(negedge clk);
          chk($sformatf("abort_idle_d%0d", d), {tx[d], tx_en[d], busy[d], done[d]}, 4'b1000);
          chk($sformatf("abort_expected_d%0d", d), e.abort, 1'b1);
        end else begin
          chk($sformatf("resp_data_d%0d", d), dec, e.data);
          @(negedge clk);
          chk($sformatf("done_state_d%0d", d), {done[d], tx_en[d], busy[d], tx[d]}, 4'b1001);
          @(negedge clk);
          chk($sformatf("done_pulse_d%0d", d), done[d], 1'b0);
          chk($sformatf("abort_expected_d%0d", d), e.abort, 1'b0);
        end
      end else if (tx[d] !== 1'b1 || tx_en[d] !== 1'b0 || busy[d] !== 1'b0 || done[d] !== 1'b0) begin
        idle_bad[d]++;
      end
    end
  endtask

  initial begin
    fork
      mon(0);
      mon(1);
    join_none
  end

  initial begin
    int n;
    n_chk = 0; n_fail = 0; idle_bad[0] = 0; idle_bad[1] = 0;
    reset = 1'b1; rx = 2'b11; payload0 = 16'hA55A; payload1 = 16'hA55A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx, 2'b11);
    chk("rst_tx_en", tx_en, 2'b00);
    chk("rst_busy", busy, 2'b00);
    chk("rst_pulses", {am, done, ferr}, 6'd0);
    @(posedge clk); #1 reset = 1'b0;
    idle(5);

    // Basic match and 0x5A,0xA5 response.
    push(0, RESP, 16'hA55A, 0); send_byte(0, 8'h01, 1, 1); idle(200);
    // Other addresses are ignored.
    send_byte(0, 8'h02, 1, 1); idle(16);
    send_byte(0, 8'hFF, 1, 1); idle(40);
    // Bad stop bit, then a good frame.
    push(0, FERR, '0, 0); send_byte(0, 8'h01, 1, 0); idle(40);
    push(0, RESP, 16'hA55A, 0); send_byte(0, 8'h01, 1, 1); idle(200);
    // Short glitch, then a match; payload changes mid-flight.
    rx[0] = 1'b0; repeat (2) @(posedge clk); #1 rx[0] = 1'b1; idle(40);
    push(0, RESP, 16'hA55A, 0); send_byte(0, 8'h01, 1, 1); idle(20);
    payload0 = 16'h0FF0; idle(200);
    // Parity instance: good parity, then bad parity.
    push(1, RESP, 16'hA55A, 0); send_byte(1, 8'h01, 1, 1); idle(220);
    push(1, FERR, '0, 0); send_byte(1, 8'h01, 0, 1); idle(60);
    // Reset midway through byte 0, then a full response.
    push(0, RESP, 16'h0FF0, 1);
    fork
      send_byte(0, 8'h01, 1, 1);
      begin
        n = 0;
        while (am[0] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        chk("abort_am_seen", am[0], 1'b1);
        repeat (TURN + 4 * CPB + 4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
      end
    join
    idle(60);
    push(0, RESP, 16'h0FF0, 0); send_byte(0, 8'h01, 1, 1); idle(200);

    chk("idle_bad_d0", idle_bad[0], 0);
    chk("idle_bad_d1", idle_bad[1], 0);
    chk("pending_d0", q0.size(), 0);
    chk("pending_d1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
